// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Included by dmem_array and dmem_responder.
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read and no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: IDLE/ACCESS/RESP FSM in front of a word RAM.
// Optional DMEM_ERR_EN adds MemErr for misaligned or out-of-range addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemAddress,
  input  logic [31:0] MemWriteData,
  output logic [31:0] ReadData,
  output logic        MemValid,
`ifdef DMEM_ERR_EN
  output logic        MemErr,
`endif
  output logic        Busy
);

  dmem_state_t            state, next_state;
  logic [DMEM_CNT_W-1:0]  cnt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DMEM_WORD_W-1:0] wdata_q;
  logic                   write_q;
  logic                   err_q;
  logic                   err_flag;
  logic [DMEM_WORD_W-1:0] hold_q;
  logic                   array_we;
  logic [DMEM_WORD_W-1:0] array_rdata;
  logic                   req;

  assign req = MemRead | MemWrite;

`ifdef DMEM_ERR_EN
  assign err_flag = (|MemAddress[1:0]) | (|MemAddress[31:ADDR_WIDTH+2]);
  assign MemErr   = (state == RESP) && err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{MemAddress[1:0], MemAddress[31:ADDR_WIDTH+2]};
  assign err_flag = 1'b0;
`endif

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    (array_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (array_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hold_q <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= MemAddress[ADDR_WIDTH+1:2];
            wdata_q <= MemWriteData;
            write_q <= MemWrite;
            err_q   <= err_flag;
            cnt     <= DMEM_CNT_W'(LATENCY - 1);
          end
        end
        ACCESS: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        RESP: begin
          if (!write_q) hold_q <= err_q ? '0 : array_rdata;
        end
        default: ;
      endcase
    end
  end

  // The RAM is touched only on the final ACCESS edge; a reset on that edge discards the write.
  always_comb begin
    next_state = state;
    MemValid   = 1'b0;
    Busy       = 1'b0;
    array_we   = 1'b0;
    case (state)
      IDLE: begin
        if (req) next_state = ACCESS;
      end
      ACCESS: begin
        Busy = 1'b1;
        if (cnt == '0) begin
          next_state = RESP;
          array_we   = write_q && !err_q && !rst;
        end
      end
      RESP: begin
        Busy       = 1'b1;
        MemValid   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Read data is live from the RAM during RESP, then held until the next read finishes.
  always_comb begin
    ReadData = hold_q;
    if (state == RESP && !write_q) ReadData = err_q ? '0 : array_rdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (define DMEM_ERR_EN to cover MemErr).
module tb_dmem_responder;

  localparam int ADDR_WIDTH = 10;
  localparam int LATENCY    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic [31:0] ReadData;
  logic        MemValid;
  logic        Busy;
`ifdef DMEM_ERR_EN
  logic        MemErr;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [int];
  logic [31:0] hold_model = 32'h0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .ReadData     (ReadData),
    .MemValid     (MemValid),
`ifdef DMEM_ERR_EN
    .MemErr       (MemErr),
`endif
    .Busy         (Busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
    end
  endtask

  function automatic logic isFlagged(input logic [31:0] addr);
`ifdef DMEM_ERR_EN
    logic [31:0] a;
    a = addr;
    return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'h0);
`else
    return (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int wordIndex(input logic [31:0] addr);
    return int'(addr[ADDR_WIDTH+1:2]);
  endfunction

  // Reference model: update the word store / held read data and queue the response.
  task automatic pushExpected(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input string tag);
    exp_t e;
    logic fl;
    fl = isFlagged(addr);
    if (wr) begin
      if (!fl) model[wordIndex(addr)] = data;
    end else if (rd) begin
      if (fl) hold_model = 32'h0;
      else if (model.exists(wordIndex(addr))) hold_model = model[wordIndex(addr)];
      else hold_model = 32'hxxxx_xxxx;
    end
    e.data = hold_model;
    e.err  = fl;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && MemValid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 32'(MemValid), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.tag, "_data"}, ReadData, e.data);
`ifdef DMEM_ERR_EN
        checkOutput({e.tag, "_err"}, 32'(MemErr), 32'(e.err));
`endif
      end
    end
  end

  // Hold a request for txns back-to-back transactions, checking Busy/MemValid every cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input int txns, input string tag);
    @(posedge clk); #1;
    MemRead      = rd;
    MemWrite     = wr;
    MemAddress   = addr;
    MemWriteData = data;
    for (int t = 0; t < txns; t++) pushExpected(rd, wr, addr, data, $sformatf("%s_t%0d", tag, t));
    for (int k = 0; k < txns * (LATENCY + 2); k++) begin
      int pos;
      pos = k % (LATENCY + 2);
      @(negedge clk);
      checkOutput($sformatf("%s_busy_c%0d", tag, k), 32'(Busy), 32'(pos != 0));
      checkOutput($sformatf("%s_valid_c%0d", tag, k), 32'(MemValid), 32'(pos == LATENCY + 1));
    end
    @(posedge clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemAddress   = 32'h0;
    MemWriteData = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_readdata", ReadData, 32'h0);
    checkOutput("reset_valid", 32'(MemValid), 32'h0);
    checkOutput("reset_busy", 32'(Busy), 32'h0);
`ifdef DMEM_ERR_EN
    checkOutput("reset_err", 32'(MemErr), 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1, "wr40");
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1, "rd40");
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1, "rd40b");
    applyStimulus(1'b1, 1'b1, 32'h80, 32'h12345678, 1, "both80");
    @(negedge clk);
    checkOutput("hold_after_both", ReadData, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1, "rd80");

`ifdef DMEM_ERR_EN
    applyStimulus(1'b0, 1'b1, 32'h41, 32'h33, 1, "errwr41");
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1, "rd40_after_err");
`endif

    applyStimulus(1'b0, 1'b1, 32'h100, 32'h11111111, 1, "wr100");
    @(posedge clk); #1;
    MemWrite     = 1'b1;
    MemAddress   = 32'h100;
    MemWriteData = 32'h22222222;
    @(negedge clk);
    checkOutput("rstmid_busy_c0", 32'(Busy), 32'h0);
    @(posedge clk); #1;
    rst      = 1'b1;
    MemWrite = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_busy_c1", 32'(Busy), 32'h1);
    checkOutput("rstmid_valid_c1", 32'(MemValid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_busy_c2", 32'(Busy), 32'h0);
    checkOutput("rstmid_valid_c2", 32'(MemValid), 32'h0);
    // After reset ReadData returns to 0 in the model as well.
    hold_model = 32'h0;
    checkOutput("rstmid_readdata", ReadData, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1, "rd100");

    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 2, "held40");

    applyStimulus(1'b0, 1'b1, 32'h1040, 32'h0000A5A5, 1, "wr1040");
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1, "alias40");
    applyStimulus(1'b1, 1'b0, 32'h42, 32'h0, 1, "alias42");

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
